// File: rtl/radio_fifo_axil_slave.sv
// AXI4-Lite register slave exposing a radio sample-capture FIFO to software.
// Registers: CTRL (enable/flush), SCRATCH, DATA (pop on read), STATUS (count/flags).
module radio_fifo_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 1024
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic [31:0]                       samp_tdata,
  input  logic                              samp_tvalid,
  output logic                              irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  logic             started;
  logic             aw_held, w_held;
  logic [1:0]       aw_reg;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic             enable;
  logic [31:0]      scratch;
  logic             ovf, udf;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      mem [FIFO_DEPTH];

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic empty, full, pop, push, flush, capture, ovf_ev, udf_ev, stat_clr;
  logic [1:0]  rd_sel;
  logic [31:0] status, rd_mux;

  assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
  assign w_hs   = s00_axi_wvalid & s00_axi_wready;
  assign b_hs   = s00_axi_bvalid & s00_axi_bready;
  assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
  assign r_hs   = s00_axi_rvalid & s00_axi_rready;
  assign commit = aw_held & w_held;

  assign rd_sel   = s00_axi_araddr[3:2];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign pop      = ar_hs & (rd_sel == 2'd2) & ~empty;
  assign udf_ev   = ar_hs & (rd_sel == 2'd2) & empty;
  assign flush    = commit & (aw_reg == 2'd0) & w_strb[0] & w_data[1];
  assign capture  = samp_tvalid & enable & ~flush;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the sample.
  assign push     = capture & (~full | pop);
  assign ovf_ev   = capture & full & ~pop;
  assign stat_clr = commit & (aw_reg == 2'd3) & w_strb[2];

  assign status = {12'd0, udf, ovf, full, empty, 5'd0, 11'(count)};

  assign s00_axi_bresp = 2'b00;
  assign s00_axi_rresp = 2'b00;
  assign irq           = ovf;

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      2'd0:    rd_mux = {31'd0, enable};
      2'd1:    rd_mux = scratch;
      2'd2:    rd_mux = empty ? 32'd0 : mem[rd_ptr];
      default: rd_mux = status;
    endcase
  end

  // Write address/data channels: each side latches independently, commit once both held.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      started         <= 1'b0;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_reg          <= '0;
      w_data          <= '0;
      w_strb          <= '0;
    end else begin
      started <= 1'b1;
      if (!started) begin
        s00_axi_awready <= 1'b1;
        s00_axi_wready  <= 1'b1;
      end
      if (aw_hs) begin
        s00_axi_awready <= 1'b0;
        aw_held         <= 1'b1;
        aw_reg          <= s00_axi_awaddr[3:2];
      end
      if (w_hs) begin
        s00_axi_wready <= 1'b0;
        w_held         <= 1'b1;
        w_data         <= s00_axi_wdata;
        w_strb         <= s00_axi_wstrb;
      end
      if (commit) begin
        aw_held        <= 1'b0;
        w_held         <= 1'b0;
        s00_axi_bvalid <= 1'b1;
      end
      if (b_hs) begin
        s00_axi_bvalid  <= 1'b0;
        s00_axi_awready <= 1'b1;
        s00_axi_wready  <= 1'b1;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      if (!started) s00_axi_arready <= 1'b1;
      if (ar_hs) begin
        s00_axi_arready <= 1'b0;
        s00_axi_rvalid  <= 1'b1;
        s00_axi_rdata   <= rd_mux;
      end
      if (r_hs) begin
        s00_axi_rvalid  <= 1'b0;
        s00_axi_arready <= 1'b1;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      enable  <= 1'b0;
      scratch <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      if (commit && aw_reg == 2'd0 && w_strb[0]) enable <= w_data[0];
      if (commit && aw_reg == 2'd1) begin
        for (int b = 0; b < 4; b++)
          if (w_strb[b]) scratch[8*b +: 8] <= w_data[8*b +: 8];
      end
      // Set beats clear when both land in the same cycle.
      if (ovf_ev)                      ovf <= 1'b1;
      else if (stat_clr && w_data[18]) ovf <= 1'b0;
      if (udf_ev)                      udf <= 1'b1;
      else if (stat_clr && w_data[19]) udf <= 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (push) mem[wr_ptr] <= samp_tdata;
  end

endmodule

// File: tb/tb_radio_fifo_axil_slave.sv
// Bench for radio_fifo_axil_slave: queue-based register/FIFO model plus directed scenarios.
module tb_radio_fifo_axil_slave;
  localparam int DEPTH = 1024;

  logic        clk, rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, samp_tdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        samp_tvalid, irq;

  int checks = 0;
  int errors = 0;

  radio_fifo_axil_slave #(.FIFO_DEPTH(DEPTH)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .samp_tdata(samp_tdata), .samp_tvalid(samp_tvalid), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s act=no_handshake exp=handshake", name);
  endtask

  // Behavioural model: queue for the FIFO, plain variables for registers.
  logic [31:0] m_q[$];
  logic [31:0] exp_r[$];
  logic        m_en, m_ovf, m_udf, m_aw, m_w;
  logic [31:0] m_scr, m_wd, rd;
  logic [1:0]  m_wa;
  logic [3:0]  m_ws;
  logic        old_en, popd, fl, ovf_ev, udf_ev;
  int          sz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete(); exp_r.delete();
      m_en = 0; m_ovf = 0; m_udf = 0; m_aw = 0; m_w = 0; m_scr = 0;
      m_wd = 0; m_wa = 0; m_ws = 0;
    end else begin
      old_en = m_en; sz = m_q.size(); popd = 0; fl = 0; ovf_ev = 0; udf_ev = 0;
      if (arvalid && arready) begin
        case (araddr[3:2])
          2'd0: rd = {31'd0, m_en};
          2'd1: rd = m_scr;
          2'd2: if (sz == 0) begin rd = 0; udf_ev = 1; end
                else begin rd = m_q[0]; popd = 1; end
          default: begin
            rd = 32'(sz);
            rd[16] = (sz == 0);
            rd[17] = (sz == DEPTH);
            rd[18] = m_ovf;
            rd[19] = m_udf;
          end
        endcase
        exp_r.push_back(rd);
      end
      if (m_aw && m_w) begin
        case (m_wa)
          2'd0: if (m_ws[0]) begin m_en = m_wd[0]; fl = m_wd[1]; end
          2'd1: for (int b = 0; b < 4; b++) if (m_ws[b]) m_scr[8*b +: 8] = m_wd[8*b +: 8];
          2'd3: if (m_ws[2]) begin
                  if (m_wd[18]) m_ovf = 0;
                  if (m_wd[19]) m_udf = 0;
                end
          default: ;
        endcase
        m_aw = 0; m_w = 0;
      end
      if (popd) void'(m_q.pop_front());
      if (samp_tvalid && old_en && !fl) begin
        if (m_q.size() < DEPTH) m_q.push_back(samp_tdata);
        else ovf_ev = 1;
      end
      if (fl) m_q.delete();
      if (ovf_ev) m_ovf = 1;
      if (udf_ev) m_udf = 1;
      if (awvalid && awready) begin m_aw = 1; m_wa = awaddr[3:2]; end
      if (wvalid && wready) begin m_w = 1; m_wd = wdata; m_ws = wstrb; end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("irq", {31'd0, irq}, {31'd0, m_ovf});
      if (bvalid) check("bresp", {30'd0, bresp}, 32'd0);
      if (rvalid && rready) begin
        check("rresp", {30'd0, rresp}, 32'd0);
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdata_unexpected act=%h exp=none", rdata);
        end else begin
          check("rdata", rdata, exp_r[0]);
          void'(exp_r.pop_front());
        end
      end
    end
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n; logic ha, hw, hb;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1; n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      @(posedge clk); ha = awvalid && awready; hw = wvalid && wready; #1;
      if (ha) awvalid = 0;
      if (hw) wvalid = 0;
      n++;
    end
    if (awvalid || wvalid) begin timeout("aw_w"); awvalid = 0; wvalid = 0; end
    n = 0; hb = 0;
    while (!hb && n < 50) begin @(posedge clk); hb = bvalid; #1; n++; end
    bready = 0;
    if (!hb) timeout("b");
  endtask

  task automatic ar_issue(input logic [3:0] a);
    int n; logic h;
    araddr = a; arvalid = 1; n = 0; h = 0;
    while (!h && n < 50) begin @(posedge clk); h = arready; #1; n++; end
    arvalid = 0;
    if (!h) timeout("ar");
  endtask

  task automatic r_take(output logic [31:0] d);
    int n; logic h;
    rready = 1; n = 0; h = 0; d = 0;
    while (!h && n < 50) begin @(posedge clk); h = rvalid; d = rdata; #1; n++; end
    rready = 0;
    if (!h) timeout("r");
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    ar_issue(a);
    r_take(d);
  endtask

  task automatic push_n(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      samp_tdata = base + i; samp_tvalid = 1;
      @(posedge clk); #1;
    end
    samp_tvalid = 0;
  endtask

  task automatic wait_bvalid();
    int n; n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bvalid) timeout("bvalid");
  endtask

  // Hold bready low for five cycles and confirm nothing else is accepted meanwhile.
  task automatic hold_b(input string tag);
    for (int i = 0; i < 5; i++) begin
      check({tag, "_bvalid_hold"}, {31'd0, bvalid}, 32'd1);
      check({tag, "_no_2nd_write"}, {30'd0, awready, wready}, 32'd0);
      @(posedge clk); #1;
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    check({tag, "_b_done_rdy"}, {30'd0, bvalid, awready}, 32'd1);
  endtask

  logic [31:0] d;
  logic        h;

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; awaddr = 0; araddr = 0; awprot = 0; arprot = 0; awvalid = 0; wvalid = 0;
    wdata = 0; wstrb = 0; bready = 0; arvalid = 0; rready = 0; samp_tdata = 0; samp_tvalid = 0;
    repeat (3) @(posedge clk); #1;
    check("rst_outputs", {25'd0, awready, wready, bvalid, arready, rvalid, irq, |rdata}, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    check("rdy_after_rst", {29'd0, awready, wready, arready}, 32'd7);

    // Test 1: RW, RO and W1C semantics.
    axi_write(4'h0, 32'd1, 4'hF);
    axi_write(4'h4, 32'd2, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'hC, 32'd4, 4'hF);
    axi_read(4'h0, d); check("t1_ctrl", d, 32'h1);
    axi_read(4'h4, d); check("t1_scratch", d, 32'h2);
    axi_read(4'h8, d); check("t1_data_empty", d, 32'h0);
    axi_read(4'hC, d); check("t1_status", d, 32'h0009_0000);
    axi_write(4'hC, 32'h0008_0000, 4'hF);
    axi_read(4'hC, d); check("t1_udf_clear", d, 32'h0001_0000);

    // Test 2: ordered capture and drain.
    push_n(32'hA0, 10);
    axi_read(4'hC, d); check("t2_count10", d, 32'h0000_000A);
    for (int i = 0; i < 10; i++) begin
      axi_read(4'h8, d); check("t2_pop", d, 32'hA0 + i);
    end
    axi_read(4'hC, d); check("t2_status_end", d, 32'h0001_0000);

    // Test 3: overflow and irq.
    push_n(32'h1000_0000, DEPTH + 3);
    check("t3_irq_set", {31'd0, irq}, 32'd1);
    axi_read(4'hC, d); check("t3_status_full", d, 32'h0006_0400);
    axi_write(4'hC, 32'h0004_0000, 4'hF);
    check("t3_irq_clr", {31'd0, irq}, 32'd0);
    axi_read(4'hC, d); check("t3_status_clr", d, 32'h0002_0400);

    // Test 4: pop and push in the same cycle while full.
    araddr = 4'h8; arvalid = 1; samp_tdata = 32'hBEEF; samp_tvalid = 1;
    @(posedge clk); h = arready; #1;
    arvalid = 0; samp_tvalid = 0;
    check("t4_ar_hs", {31'd0, h}, 32'd1);
    r_take(d); check("t4_oldest", d, 32'h1000_0000);
    axi_read(4'hC, d); check("t4_status", d, 32'h0002_0400);

    // Test 5a: AW leads W by three cycles, slow bready.
    awaddr = 4'h4; awvalid = 1; bready = 0;
    @(posedge clk); h = awready; #1; awvalid = 0;
    check("t5a_aw_hs", {31'd0, h}, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    check("t5a_aw_blocked", {31'd0, awready}, 32'd0);
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); h = wready; #1; wvalid = 0;
    check("t5a_w_hs", {31'd0, h}, 32'd1);
    wait_bvalid();
    hold_b("t5a");
    axi_read(4'h4, d); check("t5a_scratch", d, 32'h1234_5678);

    // Test 5b: W leads AW, partial strobes.
    wdata = 32'hCAFE_F00D; wstrb = 4'b0011; wvalid = 1;
    @(posedge clk); h = wready; #1; wvalid = 0;
    check("t5b_w_hs", {31'd0, h}, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    check("t5b_w_blocked", {31'd0, wready}, 32'd0);
    awaddr = 4'h4; awvalid = 1;
    @(posedge clk); h = awready; #1; awvalid = 0;
    check("t5b_aw_hs", {31'd0, h}, 32'd1);
    wait_bvalid();
    hold_b("t5b");
    axi_read(4'h4, d); check("t5b_scratch", d, 32'h1234_F00D);

    // Flush keeps ENABLE and reads back as 0.
    axi_write(4'h0, 32'h3, 4'hF);
    axi_read(4'h0, d); check("flush_ctrl", d, 32'h1);
    axi_read(4'hC, d); check("flush_status", d, 32'h0001_0000);

    // Test 6: reset while a read response is pending.
    push_n(32'h55, 5);
    ar_issue(4'hC);
    check("t6_rvalid_pend", {31'd0, rvalid}, 32'd1);
    check("t6_rdata_pend", rdata, 32'h0000_0005);
    rst_n = 0; #1;
    check("t6_async_clear", {27'd0, rvalid, awready, wready, arready, |rdata}, 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("t6_arready", {31'd0, arready}, 32'd1);
    axi_read(4'hC, d); check("t6_status", d, 32'h0001_0000);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/radio_fifo_axil_slave.md
Name: radio_fifo_axil_slave

Overview:
AXI4-Lite responder that sits behind the VIP/PS master and exposes a sample-capture FIFO to software. It is fed by the radio datapath as a valid-only sample stream with no backpressure. It provides control, scratch, FIFO-pop and status registers. It is the slave end of the AXI4-Lite register path that the peripheral bench exercises.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width (fixed 32).
C_S_AXI_ADDR_WIDTH, 4, byte address width (4 registers).
FIFO_DEPTH, 1024, sample entries; power of 2, at least 4.

Ports:
s00_axi_aclk  in  1  clock; all logic on the rising edge.
s00_axi_aresetn  in  1  asynchronous active-low reset.
s00_axi_awaddr  in  4  write address.
s00_axi_awprot  in  3  ignored.
s00_axi_awvalid/awready  in/out  1  AW handshake.
s00_axi_wdata  in  32  write data.
s00_axi_wstrb  in  4  byte enables.
s00_axi_wvalid/wready  in/out  1  W handshake.
s00_axi_bresp  out  2  always 2'b00.
s00_axi_bvalid/bready  out/in  1  B handshake.
s00_axi_araddr  in  4  read address.
s00_axi_arprot  in  3  ignored.
s00_axi_arvalid/arready  in/out  1  AR handshake.
s00_axi_rdata  out  32  read data.
s00_axi_rresp  out  2  always 2'b00.
s00_axi_rvalid/rready  out/in  1  R handshake.
samp_tdata  in  32  sample from the radio datapath.
samp_tvalid  in  1  sample strobe; no ready signal.
irq  out  1  high while the overflow flag is set.

Behaviour:
- Reset: all outputs 0, CTRL=0, SCRATCH=0, FIFO empty, sticky flags 0. awready, wready and arready go high in the first cycle after release.
- Register decode uses addr[3:2]; addr[1:0] is ignored.
- 0x0 CTRL (RW): bit0 ENABLE; bit1 FLUSH, self-clearing, always reads 0; other bits read 0.
- 0x4 SCRATCH (RW): 32 bits, WSTRB honoured per byte.
- 0x8 DATA (RO): an AR handshake pops the FIFO head into rdata. If the FIFO is empty, rdata=0, no pop occurs, and UNDERFLOW is set.
- 0xC STATUS: [10:0] count (0..FIFO_DEPTH); [16] empty; [17] full; [18] OVERFLOW sticky; [19] UNDERFLOW sticky. Writing 1 to bit 18 or 19 clears that bit; all other bits are RO.
- Writes to RO bits or RO registers are ignored. Responses are always OKAY.
- Write channel:
  - AW and W are accepted independently, in either order. Each ready drops after its handshake until the write commits.
  - The write commits in the cycle both are held. bvalid rises the next cycle and holds until bready.
  - awready and wready re-assert the cycle after the B handshake. Only one write is outstanding.
- Read channel:
  - arready is high only while rvalid=0.
  - On an AR handshake, rdata is registered and rvalid rises the next cycle. rdata and rvalid hold until rready.
  - arready re-asserts the cycle after the R handshake. Only one read is outstanding.
- Push rule: when samp_tvalid=1 and ENABLE=1, push if not full. If full and no pop occurs that cycle, drop the sample and set OVERFLOW.
- Simultaneous push and pop: both occur and count is unchanged. This also applies when full; no overflow is flagged in that case.
- Pointer and count arithmetic: pointers are clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is clog2(FIFO_DEPTH)+1 bits.
- Flush takes effect the cycle the CTRL write commits: pointers=0, count=0.
  - Flush beats a push in the same cycle; that sample is dropped and not flagged.
  - Sticky flags are unaffected by flush.
- A CTRL write with ENABLE=0 stops capture from the next cycle.
- Simultaneous AXI read of STATUS and a push or pop: the read returns the pre-update count.
- A write to STATUS and a flag-setting event in the same cycle: set wins.
- Reset asserted mid-transaction: outputs clear immediately (asynchronous). The in-flight transaction is abandoned and no response is issued.

Test Plan:
1. Write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read back -> 0x0=0x1, 0x4=0x2, 0x8=0 (plus UNDERFLOW), 0xC=0x00090000 (empty + UNDERFLOW); every response OKAY.
2. ENABLE=1, push 0xA0..0xA9 -> STATUS count=10; ten DATA reads return 0xA0..0xA9 in order; final STATUS=0x00010000.
3. Push FIFO_DEPTH+3 samples with no reads -> count=1024, full=1, OVERFLOW=1, irq=1. Write 0x00040000 to STATUS -> irq=0, count still 1024.
4. FIFO full, then a DATA read in the same cycle as samp_tvalid -> count stays 1024, OVERFLOW stays 0, the read returns the oldest sample.
5. AW presented 3 cycles before W, with bready held low for 5 cycles -> SCRATCH updates when W arrives; bvalid holds 5 cycles; no second write is accepted meanwhile. Repeat with W before AW.
6. Reset asserted while rvalid=1 and count=5 -> rvalid=0 and rdata=0 immediately; after release, STATUS reads 0x00010000 and arready=1.
